// File: rtl/audio_pkg.sv
// Shared state type and system constants for the audio playback sequencer.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PREFETCH,
        STREAM,
        DRAIN
    } state_t;

    localparam int WORD_LENGTH_DEFAULT = 16;
    localparam int unsigned SYSTEM_FREQUENCY = 100000000;
    localparam int unsigned SAMPLING_FREQUENCY = 1000000;

endpackage

// File: rtl/audio_playback_sequencer.sv
// Streams a sample-memory region into a serializer, one word ahead.
// Define PLAYBACK_LOOP_EN to add loop_i and continuous region repeat.
module audio_playback_sequencer
    import audio_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   play_i,
    input  logic                   stop_i,
    input  logic [ADDR_WIDTH-1:0]  start_addr_i,
    input  logic [ADDR_WIDTH-1:0]  end_addr_i,
`ifdef PLAYBACK_LOOP_EN
    input  logic                   loop_i,
`endif
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic                   mem_rd_o,
    input  logic [WORD_LENGTH-1:0] mem_data_i,
    output logic                   ser_enable_o,
    output logic [WORD_LENGTH-1:0] ser_data_o,
    input  logic                   ser_done_i,
    output logic                   busy_o,
    output logic                   done_o
);

    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [WORD_LENGTH-1:0] next_q, next_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic rd_q, rd_d;
    logic en_q, en_d;
    logic done_q, done_d;
    logic pend_q, pend_d;
    logic at_end, last;
    logic [ADDR_WIDTH-1:0] step;

`ifdef PLAYBACK_LOOP_EN
    logic loop_q, loop_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) loop_q <= 1'b0;
        else         loop_q <= loop_d;
    end
`else
    logic loop_q;
    assign loop_q = 1'b0;
`endif

    // Looping regions wrap back to start instead of finishing.
    assign at_end = (addr_q == end_q);
    assign last   = at_end && !loop_q;
    assign step   = at_end ? start_q : addr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        start_d = start_q;
        end_d   = end_q;
        next_d  = next_q;
        data_d  = data_q;
        rd_d    = 1'b0;
        en_d    = en_q;
        done_d  = 1'b0;
        pend_d  = pend_q;
`ifdef PLAYBACK_LOOP_EN
        loop_d  = loop_q;
`endif
        if (state_q != IDLE && stop_i) begin
            state_d = IDLE;
            en_d    = 1'b0;
            pend_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (play_i && !stop_i) begin
                        if (end_addr_i >= start_addr_i) begin
                            start_d = start_addr_i;
                            end_d   = end_addr_i;
                            addr_d  = start_addr_i;
                            rd_d    = 1'b1;
                            state_d = FETCH;
`ifdef PLAYBACK_LOOP_EN
                            loop_d  = loop_i;
`endif
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    data_d = mem_data_i;
                    en_d   = 1'b1;
                    if (last) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d  = step;
                        rd_d    = 1'b1;
                        state_d = PREFETCH;
                    end
                end
                PREFETCH: begin
                    if (ser_done_i) pend_d = 1'b1;
                    // Read data is valid the cycle after the strobe drops.
                    if (!rd_q) begin
                        next_d  = mem_data_i;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (ser_done_i || pend_q) begin
                        pend_d = ser_done_i && pend_q;
                        data_d = next_q;
                        if (last) begin
                            state_d = DRAIN;
                        end else begin
                            addr_d  = step;
                            rd_d    = 1'b1;
                            state_d = PREFETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (ser_done_i) begin
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            next_q  <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            end_q   <= end_d;
            next_q  <= next_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            en_q    <= en_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_rd_o     = rd_q;
    assign ser_enable_o = en_q;
    assign ser_data_o   = data_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// Randomized self-checking bench for audio_playback_sequencer.
module tb_audio_playback_sequencer;

    localparam int AW = 17;
    localparam int WL = 16;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    logic play_i = 1'b0;
    logic stop_i = 1'b0;
    logic ser_done_i = 1'b0;
    logic [AW-1:0] start_addr_i = '0;
    logic [AW-1:0] end_addr_i = '0;
    logic [AW-1:0] mem_addr_o;
    logic mem_rd_o, ser_enable_o, busy_o, done_o;
    logic [WL-1:0] mem_data_i;
    logic [WL-1:0] ser_data_o;
`ifdef PLAYBACK_LOOP_EN
    logic loop_i = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int rd_count = 0;
    int done_count = 0;
    logic [WL-1:0] seed = 16'h3c5a;
    logic [WL-1:0] seen[$];
    bit en_dropped;

    audio_playback_sequencer #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL)) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .play_i(play_i),
        .stop_i(stop_i),
        .start_addr_i(start_addr_i),
        .end_addr_i(end_addr_i),
`ifdef PLAYBACK_LOOP_EN
        .loop_i(loop_i),
`endif
        .mem_addr_o(mem_addr_o),
        .mem_rd_o(mem_rd_o),
        .mem_data_i(mem_data_i),
        .ser_enable_o(ser_enable_o),
        .ser_data_o(ser_data_o),
        .ser_done_i(ser_done_i),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [WL-1:0] word_at(input logic [AW-1:0] a);
        logic [WL-1:0] lo;
        lo = a[WL-1:0];
        return (lo * 16'h9e37) ^ seed ^ WL'(a >> WL);
    endfunction

    // Sample memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clock_i) begin
        if (mem_rd_o) begin
            mem_data_i <= word_at(mem_addr_o);
            rd_count   <= rd_count + 1;
        end else begin
            mem_data_i <= WL'($urandom);
        end
        if (done_o) done_count <= done_count + 1;
    end

    task automatic play(input logic [AW-1:0] s, input logic [AW-1:0] e);
        @(negedge clock_i);
        start_addr_i = s;
        end_addr_i   = e;
        play_i       = 1'b1;
        @(negedge clock_i);
        play_i = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clock_i);
        stop_i = 1'b1;
        @(negedge clock_i);
        stop_i = 1'b0;
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (ser_enable_o) ok = 1'b1;
            else @(negedge clock_i);
        end
    endtask

    // Serializer: latch the shown word after a gap, then pulse done.
    task automatic consume(input int n, input int gmin, input int gmax);
        seen.delete();
        for (int k = 0; k < n; k++) begin
            int g = $urandom_range(gmax, gmin);
            repeat (g) begin
                @(negedge clock_i);
                if (!ser_enable_o) en_dropped = 1'b1;
            end
            seen.push_back(ser_data_o);
            ser_done_i = 1'b1;
            @(negedge clock_i);
            ser_done_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock_i);
        checks++;
        if ({busy_o, done_o, mem_rd_o, ser_enable_o} !== 4'b0000 ||
            mem_addr_o !== '0 || ser_data_o !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b rd=%b en=%b addr=%h data=%h need all 0",
                     busy_o, done_o, mem_rd_o, ser_enable_o, mem_addr_o, ser_data_o);
        end
        reset_i = 1'b0;
        @(negedge clock_i);
    endtask

    task automatic test_basic();
        int r0 = rd_count;
        int d0;
        bit ok;
        play(17'h10, 17'h12);
        checks++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 17'h10 || ser_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_rd_latency: rd=%b addr=%h en=%b need 1/010/0",
                     mem_rd_o, mem_addr_o, ser_enable_o);
        end
        @(negedge clock_i);
        checks++;
        if (mem_rd_o !== 1'b0 || ser_enable_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_rd_once: rd=%b en=%b need 0/0", mem_rd_o, ser_enable_o);
        end
        @(negedge clock_i);
        checks++;
        if (ser_enable_o !== 1'b1 || ser_data_o !== word_at(17'h10)) begin
            failures++;
            $display("FAIL basic_first_word: en=%b data=%h need 1/%h",
                     ser_enable_o, ser_data_o, word_at(17'h10));
        end
        wait_enable(ok);
        d0 = done_count;
        consume(3, 20, 20);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen[i] !== word_at(17'h10 + AW'(i))) begin
                failures++;
                $display("FAIL basic_word%0d: got %h need %h",
                         i, seen[i], word_at(17'h10 + AW'(i)));
            end
        end
        repeat (3) @(negedge clock_i);
        checks++;
        if (done_count - d0 != 1 || busy_o !== 1'b0 || ser_enable_o !== 1'b0 ||
            rd_count - r0 != 3) begin
            failures++;
            $display("FAIL basic_end: dones=%0d busy=%b en=%b reads=%0d need 1/0/0/3",
                     done_count - d0, busy_o, ser_enable_o, rd_count - r0);
        end
    endtask

    task automatic test_reject();
        int r0 = rd_count;
        int d0 = done_count;
        play(17'd5, 17'd4);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_rd_o !== 1'b0) begin
            failures++;
            $display("FAIL reject: done=%b busy=%b rd=%b need 1/0/0",
                     done_o, busy_o, mem_rd_o);
        end
        @(negedge clock_i);
        start_addr_i = 17'd1;
        end_addr_i   = 17'd3;
        play_i       = 1'b1;
        stop_i       = 1'b1;
        @(negedge clock_i);
        play_i = 1'b0;
        stop_i = 1'b0;
        ser_done_i = 1'b1;
        @(negedge clock_i);
        ser_done_i = 1'b0;
        repeat (3) @(negedge clock_i);
        checks++;
        if (busy_o !== 1'b0 || rd_count != r0 || done_count - d0 != 1) begin
            failures++;
            $display("FAIL idle_ignore: busy=%b reads=%0d dones=%0d need 0/0/1",
                     busy_o, rd_count - r0, done_count - d0);
        end
    endtask

    task automatic test_single();
        int r0 = rd_count;
        int d0 = done_count;
        bit ok;
        play(17'd7, 17'd7);
        ser_done_i = 1'b1;
        @(negedge clock_i);
        ser_done_i = 1'b0;
        wait_enable(ok);
        checks++;
        if (!ok || ser_data_o !== word_at(17'd7) || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_word: ok=%b data=%h busy=%b need 1/%h/1",
                     ok, ser_data_o, busy_o, word_at(17'd7));
        end
        consume(1, 6, 9);
        repeat (3) @(negedge clock_i);
        checks++;
        if (rd_count - r0 != 1 || done_count - d0 != 1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_end: reads=%0d dones=%0d busy=%b need 1/1/0",
                     rd_count - r0, done_count - d0, busy_o);
        end
    endtask

    task automatic test_pending();
        logic [AW-1:0] s = 17'h200;
        int d0 = done_count;
        bit got;
        play(s, s + 17'd3);
        repeat (2) @(negedge clock_i);
        checks++;
        if (ser_enable_o !== 1'b1 || ser_data_o !== word_at(s)) begin
            failures++;
            $display("FAIL pend_first: en=%b data=%h need 1/%h",
                     ser_enable_o, ser_data_o, word_at(s));
        end
        ser_done_i = 1'b1;
        @(negedge clock_i);
        ser_done_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (ser_data_o === word_at(s + 17'd1)) got = 1'b1;
            else @(negedge clock_i);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL pend_second: data=%h need %h", ser_data_o, word_at(s + 17'd1));
        end
        consume(3, 6, 10);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen[i] !== word_at(s + AW'(i + 1))) begin
                failures++;
                $display("FAIL pend_word%0d: got %h need %h",
                         i + 1, seen[i], word_at(s + AW'(i + 1)));
            end
        end
        repeat (3) @(negedge clock_i);
        checks++;
        if (done_count - d0 != 1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL pend_end: dones=%0d busy=%b need 1/0", done_count - d0, busy_o);
        end
    endtask

    task automatic test_stop();
        logic [AW-1:0] s = 17'h0400;
        logic [AW-1:0] s2 = 17'h0a00;
        int d0 = done_count;
        bit ok;
        play(s, s + 17'd3);
        wait_enable(ok);
        consume(1, 8, 8);
        repeat (3) @(negedge clock_i);
        checks++;
        if (ser_data_o !== word_at(s + 17'd1)) begin
            failures++;
            $display("FAIL stop_second: data=%h need %h", ser_data_o, word_at(s + 17'd1));
        end
        pulse_stop();
        checks++;
        if (ser_enable_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_abort: en=%b done=%b busy=%b need 0/1/0",
                     ser_enable_o, done_o, busy_o);
        end
        play(s2, s2 + 17'd1);
        wait_enable(ok);
        checks++;
        if (!ok || ser_data_o !== word_at(s2)) begin
            failures++;
            $display("FAIL stop_restart: ok=%b data=%h need 1/%h", ok, ser_data_o, word_at(s2));
        end
        consume(2, 6, 10);
        repeat (3) @(negedge clock_i);
        checks++;
        if (seen[1] !== word_at(s2 + 17'd1) || done_count - d0 != 2 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL stop_replay: w1=%h dones=%0d busy=%b need %h/2/0",
                     seen[1], done_count - d0, busy_o, word_at(s2 + 17'd1));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [AW-1:0] s = AW'($urandom_range(131000, 0));
            int len = $urandom_range(6, 1);
            int r0 = rd_count;
            int d0 = done_count;
            bit ok;
            seed = WL'($urandom);
            play(s, s + AW'(len - 1));
            wait_enable(ok);
            play(AW'($urandom), AW'($urandom));
            consume(len, 5, 12);
            for (int i = 0; i < len; i++) begin
                checks++;
                if (seen[i] !== word_at(s + AW'(i))) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d: got %h need %h",
                             it, i, seen[i], word_at(s + AW'(i)));
                end
            end
            repeat (3) @(negedge clock_i);
            checks++;
            if (!ok || rd_count - r0 != len || done_count - d0 != 1 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_end: ok=%b reads=%0d dones=%0d busy=%b need 1/%0d/1/0",
                         it, ok, rd_count - r0, done_count - d0, busy_o, len);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        play(17'h100, 17'h105);
        wait_enable(ok);
        consume(1, 6, 6);
        d0 = done_count;
        @(negedge clock_i);
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, mem_rd_o, ser_enable_o} !== 3'b000 ||
            ser_data_o !== '0 || mem_addr_o !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b rd=%b en=%b data=%h addr=%h need zeros",
                     busy_o, mem_rd_o, ser_enable_o, ser_data_o, mem_addr_o);
        end
        @(negedge clock_i);
        reset_i = 1'b0;
        repeat (3) @(negedge clock_i);
        checks++;
        if (done_count != d0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_done: dones=%0d busy=%b need 0/0", done_count - d0, busy_o);
        end
    endtask

`ifdef PLAYBACK_LOOP_EN
    task automatic test_loop();
        bit ok;
        loop_i = 1'b1;
        play(17'd0, 17'd1);
        loop_i = 1'b0;
        wait_enable(ok);
        en_dropped = 1'b0;
        consume(5, 6, 10);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen[i] !== word_at(AW'(i % 2))) begin
                failures++;
                $display("FAIL loop_word%0d: got %h need %h", i, seen[i], word_at(AW'(i % 2)));
            end
        end
        @(negedge clock_i);
        checks++;
        if (!ok || en_dropped || ser_enable_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL loop_enable: ok=%b dropped=%b en=%b busy=%b need 1/0/1/1",
                     ok, en_dropped, ser_enable_o, busy_o);
        end
        pulse_stop();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL loop_stop: done=%b busy=%b need 1/0", done_o, busy_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_single();
        test_pending();
        test_stop();
        test_random();
        test_reset_mid();
`ifdef PLAYBACK_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, need bench to finish");
        $fatal(1);
    end

endmodule
